// File: rtl/logic_op_sched.sv
// Round-robin scheduler that serialises one requester's operand pair through a shared 1-bit
// registered logic cell, LSB first. Optional parity output: define LOGIC_OP_SCHED_PARITY_EN.
module logic_op_sched #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned NREQ  = 4,
   parameter int unsigned IDW   = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req,
   input  logic [2*NREQ-1:0]       op,
   input  logic [WIDTH*NREQ-1:0]   a_in,
   input  logic [WIDTH*NREQ-1:0]   b_in,
   output logic [NREQ-1:0]         gnt,
   output logic                    busy,
   output logic                    done,
   output logic [IDW-1:0]          done_id,
   output logic [WIDTH-1:0]        result
`ifdef LOGIC_OP_SCHED_PARITY_EN
   ,
   output logic                    res_par
`endif
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDrain,
      StDone
   } state_e;

   state_e            r_state;
   state_e            w_state_nxt;

   logic [IDW-1:0]    r_ptr;
   logic [IDW-1:0]    r_win;
   logic [1:0]        r_op;
   logic [WIDTH-1:0]  r_a;
   logic [WIDTH-1:0]  r_b;
   logic [CW-1:0]     r_bit_cnt;
   logic              r_cell_q;
   logic [WIDTH-2:0]  r_shift;
   logic [WIDTH-1:0]  r_result;
   logic [IDW-1:0]    r_done_id;
   logic [NREQ-1:0]   r_gnt;

   logic              w_found;
   logic [IDW-1:0]    w_win;
   logic [IDW-1:0]    w_ptr_nxt;
   logic [NREQ-1:0]   w_gnt_nxt;
   logic [1:0]        w_sel_op;
   logic [WIDTH-1:0]  w_sel_a;
   logic [WIDTH-1:0]  w_sel_b;
   logic              w_cell_a;
   logic              w_cell_b;
   logic              w_cell_d;
   logic              w_cap;
   logic              w_last_bit;
   logic [WIDTH-1:0]  w_shift_nxt;

   // Round-robin search: first requester at or above the pointer, wrapping.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!w_found && req[(32'(r_ptr) + 32'(i)) % NREQ]) begin
            w_found = 1'b1;
            w_win   = IDW'((32'(r_ptr) + 32'(i)) % NREQ);
         end
      end
   end

   always_comb begin
      w_ptr_nxt = (w_win == IDW'(NREQ - 1)) ? '0 : w_win + 1'b1;
      w_gnt_nxt = '0;
      w_gnt_nxt[w_win] = 1'b1;
      w_sel_op  = op[2*32'(w_win) +: 2];
      w_sel_a   = a_in[WIDTH*32'(w_win) +: WIDTH];
      w_sel_b   = b_in[WIDTH*32'(w_win) +: WIDTH];
   end

   // Shared 1-bit logic cell; XNOR built from AND/OR so it shares terms with the other ops.
   always_comb begin
      w_cell_a = r_a[r_bit_cnt];
      w_cell_b = r_b[r_bit_cnt];
      case (r_op)
         2'b00:   w_cell_d = w_cell_a & w_cell_b;
         2'b01:   w_cell_d = w_cell_a | w_cell_b;
         2'b10:   w_cell_d = w_cell_a ^ w_cell_b;
         default: w_cell_d = ~((w_cell_a & w_cell_b) ^ (w_cell_a | w_cell_b));
      endcase
   end

   // Cell output lags issue by one clock, so the first RUN cycle has nothing to capture.
   always_comb begin
      w_last_bit  = (r_bit_cnt == CW'(WIDTH - 1));
      w_cap       = ((r_state == StRun) && (r_bit_cnt != '0)) || (r_state == StDrain);
      w_shift_nxt = {r_cell_q, r_shift};
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         StIdle:  if (w_found) w_state_nxt = StRun;
         StRun:   if (w_last_bit) w_state_nxt = StDrain;
         StDrain: w_state_nxt = StDone;
         StDone:  w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ptr     <= '0;
         r_win     <= '0;
         r_op      <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_bit_cnt <= '0;
         r_cell_q  <= 1'b0;
         r_shift   <= '0;
         r_result  <= '0;
         r_done_id <= '0;
         r_gnt     <= '0;
      end else begin
         if ((r_state == StIdle) && w_found) begin
            r_op      <= w_sel_op;
            r_a       <= w_sel_a;
            r_b       <= w_sel_b;
            r_win     <= w_win;
            r_ptr     <= w_ptr_nxt;
            r_gnt     <= w_gnt_nxt;
            r_bit_cnt <= '0;
         end
         if (r_state == StRun) begin
            r_cell_q  <= w_cell_d;
            r_bit_cnt <= r_bit_cnt + 1'b1;
         end
         if (w_cap) begin
            r_shift <= w_shift_nxt[WIDTH-1:1];
         end
         if (r_state == StDrain) begin
            r_result  <= w_shift_nxt;
            r_done_id <= r_win;
         end
         if (r_state == StDone) begin
            r_gnt <= '0;
         end
      end
   end

`ifdef LOGIC_OP_SCHED_PARITY_EN
   logic r_res_par;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_res_par <= 1'b0;
      end else if (r_state == StDrain) begin
         r_res_par <= ^w_shift_nxt;
      end
   end

   assign res_par = r_res_par;
`endif

   assign gnt     = r_gnt;
   assign busy    = (r_state != StIdle);
   assign done    = (r_state == StDone);
   assign done_id = r_done_id;
   assign result  = r_result;

endmodule

// File: tb/tb_logic_op_sched.sv
// Directed-vector bench for logic_op_sched (WIDTH=8, NREQ=4); inputs change and outputs are
// sampled 1 time unit after each rising edge.
module tb_logic_op_sched;

   localparam int W  = 8;
   localparam int N  = 4;
   localparam int IW = 2;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req;
   logic [2*N-1:0]  op;
   logic [W*N-1:0]  a_in;
   logic [W*N-1:0]  b_in;
   logic [N-1:0]    gnt;
   logic            busy;
   logic            done;
   logic [IW-1:0]   done_id;
   logic [W-1:0]    result;
`ifdef LOGIC_OP_SCHED_PARITY_EN
   logic            res_par;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   logic_op_sched #(
      .WIDTH (W),
      .NREQ  (N),
      .IDW   (IW)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .op      (op),
      .a_in    (a_in),
      .b_in    (b_in),
      .gnt     (gnt),
      .busy    (busy),
      .done    (done),
      .done_id (done_id),
      .result  (result)
`ifdef LOGIC_OP_SCHED_PARITY_EN
      ,
      .res_par (res_par)
`endif
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Advance until done is seen or the limit expires; cyc = edges advanced.
   task automatic wait_done(input int limit, output int cyc);
      cyc = 0;
      do begin
         tick();
         cyc++;
      end while (!done && cyc < limit);
      check_eq("done_seen", 32'(done), 32'd1);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      req   = '0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   logic [7:0] t2_exp [4];
   int         t3_exp [4];
   int         cyc;
   int         n_done;

   initial begin
      t2_exp = '{8'h30, 8'hFC, 8'hCC, 8'h33};
      t3_exp = '{0, 2, 0, 2};
      reset = 1'b0;
      req   = '0;
      op    = '0;
      a_in  = '0;
      b_in  = '0;
      tick();
      tick();
      check_eq("rst_gnt", 32'(gnt), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_done_id", 32'(done_id), 32'd0);
      check_eq("rst_result", 32'(result), 32'd0);
      reset = 1'b1;
      tick();

      // XNOR on requester 0: A5 xnor 0F = 55
      req  = 4'b0001;
      op   = 8'h03;
      a_in = 32'h0000_00A5;
      b_in = 32'h0000_000F;
      tick();
      check_eq("t1_gnt", 32'(gnt), 32'h1);
      check_eq("t1_busy", 32'(busy), 32'd1);
      wait_done(20, cyc);
      check_eq("t1_latency", 32'(cyc + 1), 32'd10);
      check_eq("t1_id", 32'(done_id), 32'd0);
      check_eq("t1_result", 32'(result), 32'h55);
`ifdef LOGIC_OP_SCHED_PARITY_EN
      check_eq("t1_par", 32'(res_par), 32'd0);
`endif
      req = '0;
      tick();
      check_eq("t1_done_pulse", 32'(done), 32'd0);
      check_eq("t1_busy_low", 32'(busy), 32'd0);
      check_eq("t1_gnt_low", 32'(gnt), 32'd0);
      check_eq("t1_result_held", 32'(result), 32'h55);

`ifdef LOGIC_OP_SCHED_PARITY_EN
      req  = 4'b0001;
      op   = 8'h00;
      a_in = 32'h0000_0054;
      b_in = 32'h0000_0054;
      wait_done(30, cyc);
      check_eq("par_result", 32'(result), 32'h54);
      check_eq("par_bit", 32'(res_par), 32'd1);
      req = '0;
      tick();
`endif

      // All four requesters at once: round-robin 0,1,2,3, 11 cycles apart
      do_reset();
      req  = 4'b1111;
      op   = 8'hE4;
      a_in = {4{8'hF0}};
      b_in = {4{8'h3C}};
      for (int k = 0; k < 4; k++) begin
         wait_done(30, cyc);
         check_eq($sformatf("t2_gap%0d", k), 32'(cyc), (k == 0) ? 32'd10 : 32'd11);
         check_eq($sformatf("t2_id%0d", k), 32'(done_id), 32'(k));
         check_eq($sformatf("t2_res%0d", k), 32'(result), 32'(t2_exp[k]));
         req[k] = 1'b0;
      end
      tick();
      check_eq("t2_idle", 32'(busy), 32'd0);

      // Requesters 0 and 2 held continuously must alternate
      do_reset();
      req  = 4'b0101;
      op   = 8'h00;
      a_in = '0;
      b_in = '0;
      for (int k = 0; k < 4; k++) begin
         wait_done(30, cyc);
         check_eq($sformatf("t3_gap%0d", k), 32'(cyc), (k == 0) ? 32'd10 : 32'd11);
         check_eq($sformatf("t3_id%0d", k), 32'(done_id), 32'(t3_exp[k]));
      end
      req = '0;
      tick();
      tick();

      // Operands latched at grant: later input changes and dropped req are ignored
      req  = 4'b0010;
      op   = 8'h04;
      a_in = 32'h0000_1200;
      b_in = 32'h0000_4000;
      tick();
      check_eq("t4_gnt", 32'(gnt), 32'h2);
      req  = '0;
      op   = 8'hFF;
      a_in = 32'hFFFF_FFFF;
      b_in = 32'h0000_0000;
      wait_done(20, cyc);
      check_eq("t4_latency", 32'(cyc + 1), 32'd10);
      check_eq("t4_id", 32'(done_id), 32'd1);
      check_eq("t4_result", 32'(result), 32'h52);
      tick();
      check_eq("t4_gnt_low", 32'(gnt), 32'd0);

      // Reset during RUN aborts; a fresh transaction then completes with no stale done
      req  = 4'b0001;
      op   = 8'h00;
      a_in = 32'h0000_00FF;
      b_in = 32'h0000_0081;
      tick();
      check_eq("t5_gnt", 32'(gnt), 32'h1);
      tick();
      tick();
      tick();
      reset = 1'b0;
      #1;
      check_eq("t5_rst_gnt", 32'(gnt), 32'd0);
      check_eq("t5_rst_busy", 32'(busy), 32'd0);
      check_eq("t5_rst_done", 32'(done), 32'd0);
      check_eq("t5_rst_result", 32'(result), 32'd0);
      check_eq("t5_rst_id", 32'(done_id), 32'd0);
      tick();
      reset = 1'b1;
      wait_done(20, cyc);
      check_eq("t5_latency", 32'(cyc), 32'd10);
      check_eq("t5_id", 32'(done_id), 32'd0);
      check_eq("t5_result", 32'(result), 32'h81);
      req    = '0;
      n_done = 0;
      for (int k = 0; k < 15; k++) begin
         tick();
         if (done) n_done++;
      end
      check_eq("t5_no_extra_done", 32'(n_done), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
